instruction_fetch_stage: RTL and testbench
==========================================

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address loaded into the PC on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'd0: instruction word inserted into IF/ID on reset or flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port freeze  input  1  hazard stall; hold PC and IF/ID.
REQ-006 SHALL have port branch_taken  input  1  redirect fetch; flush IF/ID.
REQ-007 SHALL have port branch_target  input  32  word address of the redirect.
REQ-008 SHALL have port imem_address  output  32  word address to the instruction memory, equal to the PC.
REQ-009 SHALL have port imem_instruction  input  32  combinational memory data for imem_address.
REQ-010 SHALL have port if_id_pc  output  32  registered PC+1 of the held instruction.
REQ-011 SHALL have port if_id_instruction  output  32  registered instruction.
REQ-012 SHALL have port if_id_valid  output  1  registered; 1 = real instruction, 0 = bubble.
REQ-013 SHALL have ports fetch_count, stall_count and flush_count  output  32  each, as performance counters (see Configuration).

Function
REQ-014 The PC SHALL be a word index; sequential advance is PC+1 modulo 2^32, with 32'hFFFFFFFF wrapping to 0.
REQ-015 imem_address SHALL equal the PC combinationally; fetch latency SHALL be 0 cycles to memory and 1 cycle to IF/ID.
REQ-016 Per-edge priority SHALL be rst > branch_taken > freeze > normal advance.
REQ-017 Normal advance SHALL set PC<=PC+1, if_id_instruction<=imem_instruction, if_id_pc<=PC+1 and if_id_valid<=1.
REQ-018 freeze=1 with branch_taken=0 SHALL hold the PC, if_id_pc, if_id_instruction and if_id_valid unchanged.
REQ-019 branch_taken=1 SHALL set PC<=branch_target, if_id_instruction<=NOP_INSTR, if_id_pc<=0 and if_id_valid<=0, regardless of freeze.
REQ-020 On the edge after a branch, the instruction at branch_target SHALL enter IF/ID unless freeze or branch_taken is asserted.
REQ-021 A branch_target equal to the current PC, including a self-loop, SHALL be legal and refetch that word.
REQ-022 Consecutive branch_taken cycles SHALL each redirect the PC; IF/ID SHALL stay a bubble throughout.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set PC<=RESET_PC, if_id_instruction<=NOP_INSTR, if_id_pc<=0 and if_id_valid<=0, overriding all other inputs.
REQ-024 Reset asserted mid-stall or mid-branch SHALL discard that operation; no state SHALL survive.
REQ-025 On the first edge after rst deasserts, the block SHALL fetch the word at RESET_PC into IF/ID, subject to freeze and branch_taken.

Configuration
REQ-026 Macro FETCH_PERF_CNT_EN defined: on each non-reset edge, fetch_count SHALL increment on a normal advance, stall_count on freeze without branch, and flush_count on branch_taken.
REQ-027 With FETCH_PERF_CNT_EN defined, the counters SHALL reset to 0 and wrap from 32'hFFFFFFFF to 0.
REQ-028 Macro FETCH_PERF_CNT_EN undefined: the three counter ports SHALL remain and be tied to 32'd0, with no counter registers synthesized.

Verification
REQ-029 Reset, then 3 free-running cycles with memory returning word index+100 -> IF/ID holds (pc 1, instr 100), then (2, 101), then (3, 102); valid=1.
REQ-030 freeze=1 for 2 cycles while PC=5 -> PC stays 5 and IF/ID unchanged; on release, instr 105 enters IF/ID with if_id_pc=6.
REQ-031 branch_taken=1, target 28, with freeze=1 on the same edge -> PC=28, if_id_valid=0, instr=0; next edge loads (29, 128).
REQ-032 PC=32'hFFFFFFFF, normal advance -> PC=0 and if_id_pc=0.
REQ-033 rst=1 raised during a freeze at PC=12 -> PC=RESET_PC and valid=0; counters read 0 when FETCH_PERF_CNT_EN is defined.
REQ-034 With FETCH_PERF_CNT_EN defined, 4 fetches, 2 stalls and 1 branch after reset -> fetch_count=4, stall_count=2 and flush_count=1; with the macro undefined, all three read 0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, zero-latency memory address, IF/ID pipeline register.
// Latency: 0 cycles PC->imem_address, 1 cycle to IF/ID. Backpressure: freeze holds PC and IF/ID; branch_taken flushes.
// Optional FETCH_PERF_CNT_EN macro adds fetch/stall/flush performance counters.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] NOP_INSTR = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_vld_q, if_vld_d;

    logic        do_flush;
    logic        do_stall;
    logic        do_fetch;
    logic [31:0] pc_inc;

    // Branch beats freeze: a redirect must never be lost behind a stall.
    assign do_flush = branch_taken;
    assign do_stall = freeze & ~branch_taken;
    assign do_fetch = ~freeze & ~branch_taken;
    assign pc_inc   = pc_q + 32'd1;

    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_vld_d   = if_vld_q;
        if (do_flush) begin
            pc_d       = branch_target;
            if_pc_d    = 32'd0;
            if_instr_d = NOP_INSTR;
            if_vld_d   = 1'b0;
        end else if (do_fetch) begin
            pc_d       = pc_inc;
            if_pc_d    = pc_inc;
            if_instr_d = imem_instruction;
            if_vld_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
            if_vld_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_vld_q   <= if_vld_d;
        end
    end

    assign imem_address      = pc_q;
    assign if_id_pc          = if_pc_q;
    assign if_id_instruction = if_instr_q;
    assign if_id_valid       = if_vld_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Exactly one counter advances per non-reset edge; all wrap naturally.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (do_fetch) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (do_stall) stall_cnt_d = stall_cnt_q + 32'd1;
        if (do_flush) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory returns word index + 100.
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_instruction = imem_address + 32'd100;

    instruction_fetch_stage #(
        .RESET_PC (32'd0),
        .NOP_INSTR(32'd0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_instruction(if_id_instruction),
        .if_id_valid      (if_id_valid),
        .fetch_count      (fetch_count),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected counter value: real count with counters built in, otherwise tied to 0.
    function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                               input logic [31:0] instr, input logic vld);
        check({tag, ".pc"},    imem_address, pc);
        check({tag, ".ifpc"},  if_id_pc, ipc);
        check({tag, ".instr"}, if_id_instruction, instr);
        check({tag, ".vld"},   {31'd0, if_id_valid}, {31'd0, vld});
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] f, input logic [31:0] s,
                             input logic [31:0] b);
        check({tag, ".fetch"}, fetch_count, cnt(f));
        check({tag, ".stall"}, stall_count, cnt(s));
        check({tag, ".flush"}, flush_count, cnt(b));
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        step(); step();
        check_state("reset", 32'd0, 32'd0, 32'd0, 1'b0);
        check_cnt("reset", 0, 0, 0);

        // free-running fetch
        rst = 1'b0;
        step(); check_state("run1", 32'd1, 32'd1, 32'd100, 1'b1);
        step(); check_state("run2", 32'd2, 32'd2, 32'd101, 1'b1);
        step(); check_state("run3", 32'd3, 32'd3, 32'd102, 1'b1);
        step(); step();
        check_state("run5", 32'd5, 32'd5, 32'd104, 1'b1);
        check_cnt("run5", 5, 0, 0);

        // freeze holds everything
        freeze = 1'b1;
        step(); check_state("frz1", 32'd5, 32'd5, 32'd104, 1'b1);
        step(); check_state("frz2", 32'd5, 32'd5, 32'd104, 1'b1);
        freeze = 1'b0;
        step(); check_state("unfrz", 32'd6, 32'd6, 32'd105, 1'b1);
        check_cnt("unfrz", 6, 2, 0);

        // branch wins over freeze
        freeze = 1'b1; branch_taken = 1'b1; branch_target = 32'd28;
        step(); check_state("br28", 32'd28, 32'd0, 32'd0, 1'b0);
        freeze = 1'b0; branch_taken = 1'b0;
        step(); check_state("after_br", 32'd29, 32'd29, 32'd128, 1'b1);
        check_cnt("after_br", 7, 2, 1);

        // consecutive branches, then self-loop
        branch_taken = 1'b1; branch_target = 32'd40;
        step(); check_state("br40", 32'd40, 32'd0, 32'd0, 1'b0);
        branch_target = 32'd50;
        step(); check_state("br50", 32'd50, 32'd0, 32'd0, 1'b0);
        step(); check_state("self", 32'd50, 32'd0, 32'd0, 1'b0);
        branch_taken = 1'b0;
        step(); check_state("after_self", 32'd51, 32'd51, 32'd150, 1'b1);
        check_cnt("after_self", 8, 2, 4);

        // PC wrap
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step(); check_state("brmax", 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
        branch_taken = 1'b0;
        step(); check_state("wrap", 32'd0, 32'd0, 32'd99, 1'b1);

        // reset during freeze at PC=12
        branch_taken = 1'b1; branch_target = 32'd12;
        step();
        branch_taken = 1'b0; freeze = 1'b1;
        step(); check_state("frz12", 32'd12, 32'd0, 32'd0, 1'b0);
        check_cnt("frz12", 9, 3, 6);
        rst = 1'b1;
        step(); check_state("rst_frz", 32'd0, 32'd0, 32'd0, 1'b0);
        check_cnt("rst_frz", 0, 0, 0);

        // counters: 4 fetches, 2 stalls, 1 branch
        rst = 1'b0; freeze = 1'b0;
        step(); check_state("post_rst", 32'd1, 32'd1, 32'd100, 1'b1);
        step(); step(); step();
        check_state("f4", 32'd4, 32'd4, 32'd103, 1'b1);
        freeze = 1'b1;
        step(); step();
        freeze = 1'b0; branch_taken = 1'b1; branch_target = 32'd7;
        step();
        branch_taken = 1'b0;
        check_state("cnt_br", 32'd7, 32'd0, 32'd0, 1'b0);
        check_cnt("cnt", 4, 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
